pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Sequences the reset and lock acquisition of the system PLL and produces a single qualified "clocks good" reset for the rest of the core. It runs from the 50 MHz board reference clock, drives the PLL `rst` input, watches the PLL `locked` output, and holds downstream logic in reset until lock has been stable for a programmable time. It also handles loss of lock, lock timeout with bounded retries, and software-requested restarts.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per reset attempt (>=1).
- `SETTLE_CYCLES`, 1024: consecutive cycles of synchronized lock required before release (>=1).
- `TIMEOUT_CYCLES`, 65536: cycles allowed in WAIT_LOCK before a retry (timeout build only).
- `MAX_RETRIES`, 3: retries before FAULT (timeout build only).
- `SYNC_STAGES`, 2: synchronizer depth for `pll_locked` (>=2).

Ports:
- `clk` in 1: 50 MHz reference clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL locked; asynchronous to `clk`.
- `restart` in 1: single-cycle restart request.
- `pll_rst` out 1: PLL reset, active high.
- `sys_rst_n` out 1: downstream reset, active low; high only in RUN.
- `ready` out 1: high only in RUN.
- `fault` out 1: high only in FAULT.
- `retry_count` out 2: retries consumed in the current attempt sequence; saturates at 3.
- `state` out 3: encoded state (RESET=0, WAIT_LOCK=1, SETTLE=2, RUN=3, FAULT=4).

## Operation
- `pll_locked` passes through `SYNC_STAGES` flops, all reset to 0, to give `locked_s`.
- There is one shared counter, sized for the largest of `RST_CYCLES`, `SETTLE_CYCLES` and `TIMEOUT_CYCLES`. It clears on every state change.
- RESET: `pll_rst`=1. After `RST_CYCLES` cycles in the state, go to WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0.
  - `locked_s`=1: go to SETTLE.
  - Timeout build, counter reaches `TIMEOUT_CYCLES`-1 with `retry_count`<`MAX_RETRIES`: increment `retry_count`, go to RESET.
  - Same timeout with `retry_count`=`MAX_RETRIES`: go to FAULT.
- SETTLE:
  - `locked_s`=0 on any cycle: go to WAIT_LOCK. The timeout restarts from 0 and `retry_count` is unchanged.
  - `SETTLE_CYCLES` consecutive cycles with `locked_s`=1: go to RUN.
- RUN: `ready`=1 and `sys_rst_n`=1. Entering RUN clears `retry_count`. `locked_s`=0 sends the block to RESET.
- FAULT: `pll_rst`=1 and `fault`=1. The block stays here until `restart` or `rst_n`.
- `restart`=1 in any state: go to RESET and clear `retry_count`. It has priority over every other transition in the same cycle.
- In SETTLE, a `locked_s` drop on the same cycle as counter completion goes to WAIT_LOCK; the drop wins.

## Timing
- All outputs are flops loaded from the next-state decode, so they change on the same edge as `state`. There are no combinational paths from inputs to outputs.
- Reset values: `state`=RESET, `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fault`=0, `retry_count`=0, counter=0, synchronizer=0.
- Asserting `rst_n` at any point, including mid-SETTLE or in RUN, forces all reset values immediately (asynchronous). Release is synchronous to the next `clk` edge.
- `pll_rst` is high for exactly `RST_CYCLES` rising edges per attempt.
- Latency from a `pll_locked` edge to a state reaction is `SYNC_STAGES`+1 cycles.
- From SETTLE entry to RUN is exactly `SETTLE_CYCLES` cycles when there is no drop.

## Configuration
- `PLL_SEQ_TIMEOUT_EN` defined: the WAIT_LOCK timeout, the retry counter and the FAULT state are compiled in, as described above.
- Not defined: WAIT_LOCK waits indefinitely and FAULT is unreachable. `fault` is tied to 0, `retry_count` is tied to 0, and `TIMEOUT_CYCLES`/`MAX_RETRIES` are ignored.

## Test plan
Use `RST_CYCLES`=16, `SETTLE_CYCLES`=64, `TIMEOUT_CYCLES`=256, `MAX_RETRIES`=3 and `SYNC_STAGES`=2 unless stated.
- Nominal power-up: release `rst_n`; raise `pll_locked` 40 cycles after `pll_rst` falls.
  - `pll_rst` is high for 16 cycles.
  - WAIT_LOCK→SETTLE occurs 3 cycles after the lock edge.
  - `ready`=`sys_rst_n`=1 exactly 64 cycles later, with `retry_count`=0.
- Settle glitch: drop `pll_locked` for 1 cycle at settle count 30.
  - The block returns to WAIT_LOCK, and `ready` stays 0 until a full 64-cycle settle after relock.
- Loss of lock in RUN: drop `pll_locked`.
  - `ready` and `sys_rst_n` fall 3 cycles later.
  - `pll_rst` is high for 16 cycles, then the block re-locks normally.
- Timeout build, `pll_locked` held at 0:
  - Three RESET/WAIT_LOCK cycles run with `retry_count` 1, 2, 3.
  - After the 4th timeout: `fault`=1, `state`=4, `pll_rst` held at 1.
  - Non-timeout build: the block stays in WAIT_LOCK for at least 1000 cycles with `fault`=0.
- `restart` pulse:
  - In FAULT: `fault`=0 and `retry_count`=0 on the next edge, then a 16-cycle `pll_rst`.
  - In RUN: `ready`=0 on the next edge.
- `rst_n` asserted mid-SETTLE: every output is at its reset value before the next `clk` edge.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Sequences PLL reset and lock acquisition from the board reference clock and
// produces a single qualified "clocks good" reset (sys_rst_n) for the core.
// The synchronized lock must be stable for SETTLE_CYCLES before release.
// Loss of lock in RUN restarts the sequence, and a restart request always
// returns the block to RESET.
// Build option: define PLL_SEQ_TIMEOUT_EN to compile in the WAIT_LOCK
// timeout, the bounded retry counter and the FAULT state. When it is not
// defined, WAIT_LOCK waits indefinitely and fault/retry_count are tied to 0.
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned SETTLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam int unsigned CNT_MAX_RS = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
`ifdef PLL_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_MAX = (CNT_MAX_RS > TIMEOUT_CYCLES) ? CNT_MAX_RS : TIMEOUT_CYCLES;
  localparam logic [1:0]  RETRY_LIMIT = (MAX_RETRIES > 3) ? 2'd3 : 2'(MAX_RETRIES);
`else
  localparam int unsigned CNT_MAX = CNT_MAX_RS;
`endif
  // The counter only ever has to reach CNT_MAX-1.
  localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  if (RST_CYCLES < 1 || SETTLE_CYCLES < 1 || SYNC_STAGES < 2 ||
      TIMEOUT_CYCLES < 1 || MAX_RETRIES > 3) begin : g_bad_params
    $error("pll_reset_sequencer: parameter out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pll_rst_q;
  logic                   sys_rst_n_q;
  logic                   ready_q;
`ifdef PLL_SEQ_TIMEOUT_EN
  logic [1:0]             retry_q, retry_d;
  logic                   fault_q;
`endif

  // Bring the asynchronous PLL lock indication into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Next-state, shared-counter and retry decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef PLL_SEQ_TIMEOUT_EN
    retry_d = retry_q;
`endif
    if (restart) begin
      state_d = ST_RESET;
`ifdef PLL_SEQ_TIMEOUT_EN
      retry_d = '0;
`endif
    end else begin
      unique case (state_q)
        ST_RESET: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            state_d = ST_WAIT_LOCK;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_SETTLE;
          end
`ifdef PLL_SEQ_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            if (retry_q < RETRY_LIMIT) begin
              retry_d = retry_q + 2'd1;
              state_d = ST_RESET;
            end else begin
              state_d = ST_FAULT;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
        ST_SETTLE: begin
          cnt_d = cnt_q + CNT_W'(1);
          // A lock drop wins over settle completion on the same cycle.
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            state_d = ST_RUN;
`ifdef PLL_SEQ_TIMEOUT_EN
            retry_d = '0;
`endif
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d = ST_RESET;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RESET;
        end
      endcase
    end
    // A restart begins a fresh RESET window even when already in RESET.
    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end
  end

  // State, counter and outputs, all loaded from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
      retry_q     <= '0;
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= (state_d == ST_RESET) || (state_d == ST_FAULT);
      sys_rst_n_q <= (state_d == ST_RUN);
      ready_q     <= (state_d == ST_RUN);
`ifdef PLL_SEQ_TIMEOUT_EN
      retry_q     <= retry_d;
      fault_q     <= (state_d == ST_FAULT);
`endif
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign state     = state_q;
`ifdef PLL_SEQ_TIMEOUT_EN
  assign fault       = fault_q;
  assign retry_count = retry_q;
`else
  assign fault       = 1'b0;
  assign retry_count = 2'b00;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: scoreboard of expected state transitions
// (state, outputs and the exact cycle), compared as the DUT produces them.
// Covers both builds; the timeout scenarios depend on PLL_SEQ_TIMEOUT_EN.
module tb_pll_reset_sequencer;

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [2:0] state;

  pll_reset_sequencer #(
    .RST_CYCLES    (16),
    .SETTLE_CYCLES (64),
    .TIMEOUT_CYCLES(256),
    .MAX_RETRIES   (3),
    .SYNC_STAGES   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fault      (fault),
    .retry_count(retry_count),
    .state      (state)
  );

  typedef struct {
    string      tag;
    int         cyc;
    logic [2:0] st;
    logic [1:0] rc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         c0;
  logic [2:0] last_state;
  logic [8:0] obs;
  int         obs_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Expected output vector for a state, from the output definitions.
  function automatic logic [8:0] exp_vec(input logic [2:0] st, input logic [1:0] rc);
    logic pr, sr, rd, ft;
    pr = (st == S_RESET) || (st == S_FAULT);
    sr = (st == S_RUN);
    rd = (st == S_RUN);
    ft = (st == S_FAULT);
    return {st, pr, sr, rd, ft, rc};
  endfunction

  function automatic logic [8:0] cur_vec();
    return {state, pll_rst, sys_rst_n, ready, fault, retry_count};
  endfunction

  task automatic push(input string tag, input int c, input logic [2:0] st, input logic [1:0] rc);
    exp_t e;
    e.tag = tag; e.cyc = c; e.st = st; e.rc = rc;
    exp_q.push_back(e);
  endtask

  task automatic at_cycle(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Wait (bounded) for the next state change, sampled on the falling edge.
  task automatic wait_transition(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state !== last_state) begin
        seen       = 1'b1;
        last_state = state;
        obs        = cur_vec();
        obs_cyc    = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (cur_vec() !== exp_vec(S_RESET, 2'd0)) begin
      n_err++;
      $display("FAIL reset_values: got %b want %b", cur_vec(), exp_vec(S_RESET, 2'd0));
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (cur_vec() !== exp_vec(S_RESET, 2'd0)) begin
      n_err++;
      $display("FAIL reset_hold: got %b want %b", cur_vec(), exp_vec(S_RESET, 2'd0));
    end
    last_state = state;
    rst_n = 1'b1;
    c0 = cyc;
  endtask

  task automatic test_nominal();
    exp_t e;
    bit   seen;
    push("nom_wait",   c0 + 16,  S_WAIT,   2'd0);
    push("nom_settle", c0 + 59,  S_SETTLE, 2'd0);
    push("nom_run",    c0 + 123, S_RUN,    2'd0);
    fork
      begin
        at_cycle(c0 + 56);
        pll_locked = 1'b1;
      end
      begin
        while (exp_q.size() > 0) begin
          wait_transition(2000, seen);
          e = exp_q.pop_front();
          n_cmp++;
          if (!seen || obs !== exp_vec(e.st, e.rc) || obs_cyc != e.cyc) begin
            n_err++;
            $display("FAIL %s: seen=%0d got %b @%0d want %b @%0d", e.tag, seen, obs, obs_cyc, exp_vec(e.st, e.rc), e.cyc);
          end
        end
      end
    join
  endtask

  task automatic test_loss_of_lock();
    exp_t e;
    bit   seen;
    int   t0;
    t0 = cyc;
    push("lol_reset",  t0 + 5,  S_RESET,  2'd0);
    push("lol_wait",   t0 + 21, S_WAIT,   2'd0);
    push("lol_settle", t0 + 33, S_SETTLE, 2'd0);
    push("lol_run",    t0 + 97, S_RUN,    2'd0);
    fork
      begin
        at_cycle(t0 + 2);
        pll_locked = 1'b0;
        at_cycle(t0 + 30);
        pll_locked = 1'b1;
      end
      begin
        while (exp_q.size() > 0) begin
          wait_transition(2000, seen);
          e = exp_q.pop_front();
          n_cmp++;
          if (!seen || obs !== exp_vec(e.st, e.rc) || obs_cyc != e.cyc) begin
            n_err++;
            $display("FAIL %s: seen=%0d got %b @%0d want %b @%0d", e.tag, seen, obs, obs_cyc, exp_vec(e.st, e.rc), e.cyc);
          end
        end
      end
    join
  endtask

  task automatic test_settle_glitch();
    exp_t e;
    bit   seen;
    int   t0;
    t0 = cyc;
    push("gl_reset",   t0 + 5,   S_RESET,  2'd0);
    push("gl_wait",    t0 + 21,  S_WAIT,   2'd0);
    push("gl_settle",  t0 + 28,  S_SETTLE, 2'd0);
    push("gl_drop",    t0 + 61,  S_WAIT,   2'd0);
    push("gl_resettle", t0 + 62, S_SETTLE, 2'd0);
    push("gl_run",     t0 + 126, S_RUN,    2'd0);
    fork
      begin
        at_cycle(t0 + 2);
        pll_locked = 1'b0;
        at_cycle(t0 + 25);
        pll_locked = 1'b1;
        at_cycle(t0 + 58);
        pll_locked = 1'b0;
        at_cycle(t0 + 59);
        pll_locked = 1'b1;
      end
      begin
        while (exp_q.size() > 0) begin
          wait_transition(2000, seen);
          e = exp_q.pop_front();
          n_cmp++;
          if (!seen || obs !== exp_vec(e.st, e.rc) || obs_cyc != e.cyc) begin
            n_err++;
            $display("FAIL %s: seen=%0d got %b @%0d want %b @%0d", e.tag, seen, obs, obs_cyc, exp_vec(e.st, e.rc), e.cyc);
          end
        end
      end
    join
  endtask

  task automatic test_restart_run();
    exp_t e;
    bit   seen;
    int   t0;
    t0 = cyc;
    push("rr_reset",  t0 + 3,  S_RESET,  2'd0);
    push("rr_wait",   t0 + 19, S_WAIT,   2'd0);
    push("rr_settle", t0 + 20, S_SETTLE, 2'd0);
    push("rr_run",    t0 + 84, S_RUN,    2'd0);
    fork
      begin
        at_cycle(t0 + 2);
        restart = 1'b1;
        at_cycle(t0 + 3);
        restart = 1'b0;
      end
      begin
        while (exp_q.size() > 0) begin
          wait_transition(2000, seen);
          e = exp_q.pop_front();
          n_cmp++;
          if (!seen || obs !== exp_vec(e.st, e.rc) || obs_cyc != e.cyc) begin
            n_err++;
            $display("FAIL %s: seen=%0d got %b @%0d want %b @%0d", e.tag, seen, obs, obs_cyc, exp_vec(e.st, e.rc), e.cyc);
          end
        end
      end
    join
  endtask

`ifdef PLL_SEQ_TIMEOUT_EN
  task automatic test_timeout_fault();
    exp_t e;
    bit   seen;
    int   t0;
    t0 = cyc;
    push("to_reset0",  t0 + 5,    S_RESET,  2'd0);
    push("to_wait0",   t0 + 21,   S_WAIT,   2'd0);
    push("to_reset1",  t0 + 277,  S_RESET,  2'd1);
    push("to_wait1",   t0 + 293,  S_WAIT,   2'd1);
    push("to_reset2",  t0 + 549,  S_RESET,  2'd2);
    push("to_wait2",   t0 + 565,  S_WAIT,   2'd2);
    push("to_reset3",  t0 + 821,  S_RESET,  2'd3);
    push("to_wait3",   t0 + 837,  S_WAIT,   2'd3);
    push("to_fault",   t0 + 1093, S_FAULT,  2'd3);
    push("rf_reset",   t0 + 1101, S_RESET,  2'd0);
    push("rf_wait",    t0 + 1117, S_WAIT,   2'd0);
    push("rf_settle",  t0 + 1123, S_SETTLE, 2'd0);
    push("rf_run",     t0 + 1187, S_RUN,    2'd0);
    fork
      begin
        at_cycle(t0 + 2);
        pll_locked = 1'b0;
        at_cycle(t0 + 1098);
        n_cmp++;
        if (state !== S_FAULT || pll_rst !== 1'b1 || fault !== 1'b1) begin
          n_err++;
          $display("FAIL fault_hold: got state=%0d pll_rst=%b fault=%b want 4/1/1", state, pll_rst, fault);
        end
        at_cycle(t0 + 1100);
        restart = 1'b1;
        at_cycle(t0 + 1101);
        restart = 1'b0;
        at_cycle(t0 + 1120);
        pll_locked = 1'b1;
      end
      begin
        while (exp_q.size() > 0) begin
          wait_transition(2000, seen);
          e = exp_q.pop_front();
          n_cmp++;
          if (!seen || obs !== exp_vec(e.st, e.rc) || obs_cyc != e.cyc) begin
            n_err++;
            $display("FAIL %s: seen=%0d got %b @%0d want %b @%0d", e.tag, seen, obs, obs_cyc, exp_vec(e.st, e.rc), e.cyc);
          end
        end
      end
    join
  endtask
`else
  task automatic test_no_timeout();
    exp_t e;
    bit   seen;
    int   t0;
    int   t1;
    t0 = cyc;
    push("nt_reset", t0 + 5,  S_RESET, 2'd0);
    push("nt_wait",  t0 + 21, S_WAIT,  2'd0);
    fork
      begin
        at_cycle(t0 + 2);
        pll_locked = 1'b0;
      end
      begin
        while (exp_q.size() > 0) begin
          wait_transition(2000, seen);
          e = exp_q.pop_front();
          n_cmp++;
          if (!seen || obs !== exp_vec(e.st, e.rc) || obs_cyc != e.cyc) begin
            n_err++;
            $display("FAIL %s: seen=%0d got %b @%0d want %b @%0d", e.tag, seen, obs, obs_cyc, exp_vec(e.st, e.rc), e.cyc);
          end
        end
      end
    join
    wait_transition(1100, seen);
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL nt_no_exit: left WAIT_LOCK to state %0d at cyc %0d, want none", obs[8:6], obs_cyc);
    end
    n_cmp++;
    if (cur_vec() !== exp_vec(S_WAIT, 2'd0)) begin
      n_err++;
      $display("FAIL nt_still_wait: got %b want %b", cur_vec(), exp_vec(S_WAIT, 2'd0));
    end
    t1 = cyc;
    push("nt_settle", t1 + 5,  S_SETTLE, 2'd0);
    push("nt_run",    t1 + 69, S_RUN,    2'd0);
    fork
      begin
        at_cycle(t1 + 2);
        pll_locked = 1'b1;
      end
      begin
        while (exp_q.size() > 0) begin
          wait_transition(2000, seen);
          e = exp_q.pop_front();
          n_cmp++;
          if (!seen || obs !== exp_vec(e.st, e.rc) || obs_cyc != e.cyc) begin
            n_err++;
            $display("FAIL %s: seen=%0d got %b @%0d want %b @%0d", e.tag, seen, obs, obs_cyc, exp_vec(e.st, e.rc), e.cyc);
          end
        end
      end
    join
  endtask
`endif

  task automatic test_async_reset_settle();
    exp_t e;
    bit   seen;
    int   t0;
    int   t1;
    t0 = cyc;
    push("ar_reset",  t0 + 3,  S_RESET,  2'd0);
    push("ar_wait",   t0 + 19, S_WAIT,   2'd0);
    push("ar_settle", t0 + 20, S_SETTLE, 2'd0);
    fork
      begin
        at_cycle(t0 + 2);
        restart = 1'b1;
        at_cycle(t0 + 3);
        restart = 1'b0;
      end
      begin
        while (exp_q.size() > 0) begin
          wait_transition(2000, seen);
          e = exp_q.pop_front();
          n_cmp++;
          if (!seen || obs !== exp_vec(e.st, e.rc) || obs_cyc != e.cyc) begin
            n_err++;
            $display("FAIL %s: seen=%0d got %b @%0d want %b @%0d", e.tag, seen, obs, obs_cyc, exp_vec(e.st, e.rc), e.cyc);
          end
        end
      end
    join
    at_cycle(t0 + 40);
    n_cmp++;
    if (state !== S_SETTLE) begin
      n_err++;
      $display("FAIL ar_in_settle: got state %0d want %0d", state, S_SETTLE);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (cur_vec() !== exp_vec(S_RESET, 2'd0)) begin
      n_err++;
      $display("FAIL ar_async_values: got %b want %b", cur_vec(), exp_vec(S_RESET, 2'd0));
    end
    repeat (2) @(negedge clk);
    last_state = state;
    t1 = cyc;
    rst_n = 1'b1;
    // Lock is still high: RESET window, then the synchronizer refills.
    push("ar_rel_wait",   t1 + 16, S_WAIT,   2'd0);
    push("ar_rel_settle", t1 + 17, S_SETTLE, 2'd0);
    push("ar_rel_run",    t1 + 81, S_RUN,    2'd0);
    while (exp_q.size() > 0) begin
      wait_transition(2000, seen);
      e = exp_q.pop_front();
      n_cmp++;
      if (!seen || obs !== exp_vec(e.st, e.rc) || obs_cyc != e.cyc) begin
        n_err++;
        $display("FAIL %s: seen=%0d got %b @%0d want %b @%0d", e.tag, seen, obs, obs_cyc, exp_vec(e.st, e.rc), e.cyc);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_nominal();
    test_loss_of_lock();
    test_settle_glitch();
    test_restart_run();
`ifdef PLL_SEQ_TIMEOUT_EN
    test_timeout_fault();
`else
    test_no_timeout();
`endif
    test_async_reset_settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
